ppu_bg_render: RTL and testbench

Background tile renderer sitting directly downstream of the VGA timing generator in the PPU. It consumes the generator's pixel counters, sync and display-active signals and fetches tile indices from an external tilemap RAM. It then fetches 4bpp pattern rows from an external pattern RAM, resolves each pixel through an internal 16-entry palette, and drives 12-bit RGB with hsync/vsync/de realigned to the pixel data.

---
 rtl/ppu_pkg.sv | 44 ++++
 rtl/ppu_palette.sv | 37 +++
 rtl/ppu_bg_render.sv | 131 +++++++++++++
 tb/tb_ppu_bg_render.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU constants, bundles and helpers.
// Used by the background renderer and the palette file.
package ppu_pkg;

    localparam int H_ACTIVE   = 800;
    localparam int V_ACTIVE   = 600;
    localparam int MAP_COLS   = 100;
    localparam int TILE_W     = 8;
    localparam int RGB_W      = 12;
    localparam int BG_LATENCY = 5;

    localparam int TM_AW  = 13;
    localparam int PAT_AW = 11;
    localparam int PAL_AW = 4;
    localparam int PIX_W  = 4;

    // Per-pixel sideband carried down the render pipe.
    typedef struct packed {
        logic [2:0] fine_x;
        logic [2:0] fine_y;
        logic       vis;
        logic       bg_en;
    } bg_side_t;

    // Generator sync/blank bundle realigned to the pixel data.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } sync_t;

    localparam sync_t SYNC_RST = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0};

    // row*100 + col, built as row*64 + row*32 + row*4 + col.
    function automatic logic [TM_AW-1:0] tm_index(
        input logic [6:0] row,
        input logic [7:0] col
    );
        logic [TM_AW-1:0] r;
        r = {6'd0, row};
        return (r << 6) + (r << 5) + (r << 2) + {5'd0, col};
    endfunction

endpackage

// File: rtl/ppu_palette.sv
// 16x12 palette register file: one sync write, one comb read.
// A read during a write to the same entry sees the old value.
module ppu_palette
    import ppu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [PAL_AW-1:0] waddr,
    input  logic [RGB_W-1:0]  wdata,
    input  logic [PAL_AW-1:0] raddr,
    output logic [RGB_W-1:0]  rdata
);

    logic [15:0][RGB_W-1:0] mem_q;
    logic [15:0][RGB_W-1:0] mem_d;

    // Next palette contents: only the strobed entry changes.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Palette storage, cleared to black on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ppu_bg_render.sv
// Background tile renderer: counters -> tilemap -> pattern -> palette.
// Five-stage stall-free pipe; sync/de realigned to the RGB output.
module ppu_bg_render
    import ppu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       counterX,
    input  logic [9:0]        counterY,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              de_in,
    input  logic              bg_enable,
    output logic              tm_re,
    output logic [TM_AW-1:0]  tm_addr,
    input  logic [7:0]        tm_data,
    output logic              pat_re,
    output logic [PAT_AW-1:0] pat_addr,
    input  logic [31:0]       pat_data,
    input  logic              pal_we,
    input  logic [PAL_AW-1:0] pal_addr,
    input  logic [RGB_W-1:0]  pal_data,
    output logic [RGB_W-1:0]  rgb,
    output logic              hsync,
    output logic              vsync,
    output logic              de
);

    logic              tm_re_q,    tm_re_d;
    logic [TM_AW-1:0]  tm_addr_q,  tm_addr_d;
    logic              pat_re_q,   pat_re_d;
    logic [PAT_AW-1:0] pat_addr_q, pat_addr_d;
    logic [RGB_W-1:0]  rgb_q,      rgb_d;

    // side_q[k] holds the sideband for stage k+1 (S1..S4).
    bg_side_t [3:0] side_q, side_d;
    // sync_q[3] drives the outputs; sync_q[2] gates rgb.
    sync_t    [3:0] sync_q, sync_d;

    bg_side_t          side0;
    logic              visible;
    logic [4:0]        nib_lsb;
    logic [PIX_W-1:0]  nib;
    logic [PAL_AW-1:0] pal_idx;
    logic [RGB_W-1:0]  pal_rdata;

    ppu_palette u_pal (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (pal_we),
        .waddr (pal_addr),
        .wdata (pal_data),
        .raddr (pal_idx),
        .rdata (pal_rdata)
    );

    // S0: visibility test and tilemap address generation.
    always_comb begin
        visible = (counterX < 11'(H_ACTIVE)) &&
                  (counterY < 10'(V_ACTIVE));
        side0.fine_x = counterX[2:0];
        side0.fine_y = counterY[2:0];
        side0.vis    = visible;
        side0.bg_en  = bg_enable;
        tm_re_d   = visible;
        tm_addr_d = '0;
        if (visible) begin
            tm_addr_d = tm_index(counterY[9:3], counterX[10:3]);
        end
    end

    // S2: pattern row address from the returned tile index.
    always_comb begin
        pat_re_d   = side_q[1].vis;
        pat_addr_d = '0;
        if (side_q[1].vis) begin
            pat_addr_d = {tm_data, side_q[1].fine_y};
        end
    end

    // S4: pick the pixel nibble and resolve it through the palette.
    always_comb begin
        nib_lsb = 5'd28 - {side_q[3].fine_x, 2'b00};
        nib     = pat_data[nib_lsb +: PIX_W];
        pal_idx = '0;
        if (side_q[3].vis && side_q[3].bg_en) begin
            pal_idx = nib;
        end
        rgb_d = sync_q[2].de ? pal_rdata : '0;
    end

    // Sideband and sync shift registers advance every clock.
    always_comb begin
        side_d = {side_q[2:0], side0};
        sync_d = {sync_q[2:0],
                  sync_t'{hsync: hsync_in,
                          vsync: vsync_in,
                          de:    de_in}};
    end

    // Pipeline registers; reset flushes the pipe to blank/sync-idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tm_re_q    <= 1'b0;
            tm_addr_q  <= '0;
            pat_re_q   <= 1'b0;
            pat_addr_q <= '0;
            rgb_q      <= '0;
            side_q     <= '0;
            sync_q     <= {4{SYNC_RST}};
        end else begin
            tm_re_q    <= tm_re_d;
            tm_addr_q  <= tm_addr_d;
            pat_re_q   <= pat_re_d;
            pat_addr_q <= pat_addr_d;
            rgb_q      <= rgb_d;
            side_q     <= side_d;
            sync_q     <= sync_d;
        end
    end

    assign tm_re    = tm_re_q;
    assign tm_addr  = tm_addr_q;
    assign pat_re   = pat_re_q;
    assign pat_addr = pat_addr_q;
    assign rgb      = rgb_q;
    assign hsync    = sync_q[3].hsync;
    assign vsync    = sync_q[3].vsync;
    assign de       = sync_q[3].de;

endmodule

// File: tb/tb_ppu_bg_render.sv
// Bench for ppu_bg_render: directed tables plus a frame-level
// reference model over randomized tile/pattern/palette content.
module tb_ppu_bg_render;
    import ppu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] counterX;
    logic [9:0]  counterY;
    logic        hsync_in, vsync_in, de_in, bg_enable;
    logic        tm_re, pat_re, pal_we;
    logic [12:0] tm_addr;
    logic [10:0] pat_addr;
    logic [7:0]  tm_data;
    logic [31:0] pat_data;
    logic [3:0]  pal_addr;
    logic [11:0] pal_data, rgb;
    logic        hsync, vsync, de;

    always #5 clk = ~clk;

    ppu_bg_render dut (
        .clk(clk), .rst_n(rst_n),
        .counterX(counterX), .counterY(counterY),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
        .bg_enable(bg_enable),
        .tm_re(tm_re), .tm_addr(tm_addr), .tm_data(tm_data),
        .pat_re(pat_re), .pat_addr(pat_addr), .pat_data(pat_data),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .rgb(rgb), .hsync(hsync), .vsync(vsync), .de(de)
    );

    // External RAMs; garbage returned when not read-enabled.
    logic [7:0]  tmap [8192];
    logic [31:0] pmem [2048];
    always @(posedge clk) begin
        tm_data  <= tm_re  ? tmap[tm_addr]  : 8'($urandom);
        pat_data <= pat_re ? pmem[pat_addr] : $urandom;
    end

    typedef struct {
        bit         de, hs, vs, bg;
        logic [3:0] idx;
        bit         tre;
        logic [12:0] ta;
        bit         pre;
        logic [10:0] pa;
    } exp_t;

    typedef struct {
        int x, y;
        bit re;
        int addr;
    } avec_t;

    exp_t        hist [6];
    logic [11:0] mpal [16];
    int          nvec = 0;
    int          nerr = 0;
    bit          chk_en = 0;
    bit          sb_hs = 1, sb_vs = 1, sb_de = 0;

    // What the renderer should do with pixel (x,y), from first principles.
    function automatic exp_t model(input int x, input int y, input bit bg);
        exp_t e;
        bit v;
        int a;
        logic [7:0] t;
        logic [31:0] row;
        v = (x < 800) && (y < 600);
        e.de = v;
        e.hs = !(x >= 856 && x < 976);
        e.vs = !(y >= 637 && y < 643);
        e.bg = bg;
        e.tre = v;
        e.pre = v;
        a = (y / 8) * 100 + (x / 8);
        e.ta = v ? 13'(a) : 13'd0;
        t = v ? tmap[a] : 8'd0;
        e.pa = v ? {t, 3'(y % 8)} : 11'd0;
        row = pmem[e.pa];
        e.idx = (v && bg) ?
            4'((row >> (4 * (7 - (x % 8)))) & 32'hF) : 4'd0;
        return e;
    endfunction

    function automatic exp_t rst_exp();
        exp_t e;
        e.de = 0; e.hs = 1; e.vs = 1; e.bg = 0; e.idx = 0;
        e.tre = 0; e.ta = 0; e.pre = 0; e.pa = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // One pixel clock: drive counters, advance model, check outputs.
    task automatic step(input int x, input int y, input bit bg,
                        input bit we = 0, input int wa = 0,
                        input int wd = 0);
        exp_t e;
        counterX  = 11'(x);
        counterY  = 10'(y);
        hsync_in  = sb_hs;
        vsync_in  = sb_vs;
        de_in     = sb_de;
        bg_enable = bg;
        pal_we    = we;
        pal_addr  = 4'(wa);
        pal_data  = 12'(wd);
        e = model(x, y, bg);
        for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = e;
        sb_hs = e.hs;
        sb_vs = e.vs;
        sb_de = e.de;
        @(posedge clk);
        #1;
        if (chk_en) begin
            chk("tm_re",    tm_re,    hist[0].tre);
            chk("tm_addr",  tm_addr,  hist[0].ta);
            chk("pat_re",   pat_re,   hist[2].pre);
            chk("pat_addr", pat_addr, hist[2].pa);
            chk("rgb", rgb,
                hist[4].de ? mpal[hist[4].idx] : 12'h000);
            chk("hsync", hsync, hist[4].hs);
            chk("vsync", vsync, hist[4].vs);
            chk("de",    de,    hist[4].de);
        end
        if (we && rst_n) mpal[wa] = 12'(wd);
        pal_we = 0;
    endtask

    // Async reset mid-cycle, then release with (cx,cy) as last counter.
    task automatic do_reset(input int cx, input int cy);
        rst_n = 0;
        #1;
        chk("rst_rgb",      rgb,      12'h000);
        chk("rst_de",       de,       1'b0);
        chk("rst_hsync",    hsync,    1'b1);
        chk("rst_vsync",    vsync,    1'b1);
        chk("rst_tm_re",    tm_re,    1'b0);
        chk("rst_pat_re",   pat_re,   1'b0);
        chk("rst_tm_addr",  tm_addr,  13'd0);
        chk("rst_pat_addr", pat_addr, 11'd0);
        chk_en = 0;
        step(cx - 1, cy, 1);
        step(cx, cy, 1);
        rst_n = 1;
        for (int i = 0; i < 16; i++) mpal[i] = 12'h000;
        for (int i = 0; i < 6; i++) hist[i] = rst_exp();
        chk_en = 1;
    endtask

    avec_t avec [7];
    int lines [15];
    int first;

    initial begin
        rst_n = 1;
        counterX = 0; counterY = 0;
        hsync_in = 1; vsync_in = 1; de_in = 0; bg_enable = 1;
        pal_we = 0; pal_addr = 0; pal_data = 0;
        for (int i = 0; i < 8192; i++) tmap[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) pmem[i] = $urandom;
        tmap[0] = 8'd7;
        pmem[{8'd7, 3'd0}] = 32'h33333333;
        tmap[1] = 8'd5;
        pmem[11'h02B] = 32'h01234567;
        for (int i = 0; i < 6; i++) hist[i] = rst_exp();
        for (int i = 0; i < 16; i++) mpal[i] = 12'h000;

        avec[0] = '{17, 9, 1, 102};
        avec[1] = '{799, 599, 1, 7499};
        avec[2] = '{800, 0, 0, 0};
        avec[3] = '{0, 0, 1, 0};
        avec[4] = '{1039, 665, 0, 0};
        avec[5] = '{7, 599, 1, 7400};
        avec[6] = '{799, 0, 1, 99};
        lines = '{0, 1, 597, 598, 599, 600, 601, 635,
                  636, 637, 642, 643, 644, 664, 665};

        #1;
        do_reset(999, 0);

        // Palette load in blanking.
        for (int i = 0; i < 16; i++)
            step(1000, 620, 1, 1, i, $urandom_range(0, 4095));
        step(1000, 620, 1, 1, 2, 12'hF80);
        step(1000, 620, 1, 1, 3, 12'h123);

        // Address generation table.
        foreach (avec[i]) begin
            step(avec[i].x, avec[i].y, 1);
            chk("tbl_tm_re",   tm_re,   avec[i].re);
            chk("tbl_tm_addr", tm_addr, avec[i].addr);
        end
        repeat (5) step(1000, 620, 1);

        // Pixel path: tile 5, row 3, fine_x 2 -> palette[2].
        step(10, 3, 1);
        step(11, 3, 1);
        step(12, 3, 1);
        chk("path_pat_addr", pat_addr, 11'h02B);
        step(13, 3, 1);
        step(14, 3, 1);
        chk("path_rgb", rgb, 12'hF80);
        repeat (5) step(1000, 620, 1);

        // Palette hazard: write index 3 while pixel 0 reads it.
        step(0, 0, 1);
        step(1, 0, 1);
        step(2, 0, 1);
        step(3, 0, 1);
        step(4, 0, 1, 1, 3, 12'hABC);
        chk("hazard_old", rgb, 12'h123);
        step(5, 0, 1);
        chk("hazard_new", rgb, 12'hABC);
        repeat (5) step(1000, 620, 1);

        // Full-width lines across active/blank/sync boundaries.
        foreach (lines[k])
            for (int x = 0; x < 1040; x++) step(x, lines[k], 1);

        // Backdrop with background disabled.
        step(1000, 620, 1, 1, 0, 12'h00F);
        for (int x = 0; x < 1040; x++) begin
            step(x, 2, 0);
            if (hist[4].de && !hist[4].bg)
                chk("bg_off_rgb", rgb, 12'h00F);
        end

        // Random pixels, bg_enable and palette writes.
        for (int n = 0; n < 3000; n++) begin
            bit w;
            w = ($urandom_range(0, 7) == 0);
            step($urandom_range(0, 1039), $urandom_range(0, 665),
                 $urandom_range(0, 3) != 0, w,
                 $urandom_range(0, 15), $urandom_range(0, 4095));
        end

        // Mid-frame reset, then resume the generator.
        do_reset(999, 10);
        for (int x = 1000; x < 1040; x++) step(x, 10, 1);
        first = -1;
        for (int x = 0; x < 1040; x++) begin
            step(x, 11, 1);
            if (de === 1'b1 && first < 0) first = x + 1;
        end
        chk("first_de_latency", first, 5);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
